// File: rtl/pdm_poly_modulator.sv
// Polyphonic PDM output stage: per-voice linear attack/release envelopes, a voice
// mix, and a selectable 1st/2nd-order sigma-delta modulator driving one pin.
module pdm_poly_modulator #(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int RAMP_DIV     = 256
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] dc_in,
  input  logic [NUM_CHANNELS-1:0]            gate_in,
  input  logic                               mode_in,
  output logic                               sig_out,
  output logic                               active_out
);

  localparam int SW = DATA_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int IW = SW + 3;
  localparam int XW = IW + 2;
  localparam int FS = NUM_CHANNELS * (2 ** DATA_WIDTH);
  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [CW-1:0]        TICK_LAST = CW'(RAMP_DIV - 1);
  localparam logic signed [IW-1:0] FS_I      = IW'(FS);
  localparam logic signed [IW-1:0] HALF_I    = IW'(FS / 2);
  localparam logic signed [XW-1:0] FS_X      = XW'(FS);
  localparam logic signed [XW-1:0] I_MAX     = XW'((2 ** (IW - 1)) - 1);
  localparam logic signed [XW-1:0] I_MIN     = XW'(-(2 ** (IW - 1)));

  // Clamp a widened integrator result so an out-of-range input can never wrap.
  function automatic logic signed [IW-1:0] sat(input logic signed [XW-1:0] v);
    if (v > I_MAX) begin
      sat = I_MAX[IW-1:0];
    end else if (v < I_MIN) begin
      sat = I_MIN[IW-1:0];
    end else begin
      sat = v[IW-1:0];
    end
  endfunction

  logic [CW-1:0]         r_tick_cnt;
  logic [DATA_WIDTH-1:0] r_env [NUM_CHANNELS];
  logic [SW-1:0]         r_sum;
  logic signed [IW-1:0]  r_i1;
  logic signed [IW-1:0]  r_i2;
  logic                  r_mode;
  logic                  r_sig;
  logic                  r_active;

  logic                  w_tick;
  logic [SW-1:0]         w_env_sum;
  logic                  w_env_any;
  logic                  w_active_nxt;
  logic signed [IW-1:0]  w_t1;
  logic signed [IW-1:0]  w_t1_wrap;
  logic signed [XW-1:0]  w_sum_x;
  logic signed [XW-1:0]  w_fb_x;
  logic signed [XW-1:0]  w_i1n_x;
  logic signed [XW-1:0]  w_i2n_x;
  logic signed [IW-1:0]  w_i1n;
  logic signed [IW-1:0]  w_i2n;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Voice mix and "any envelope open" flag from the current envelope values.
  always_comb begin
    w_env_sum = '0;
    w_env_any = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_env_sum = w_env_sum + SW'(r_env[i]);
      w_env_any = w_env_any | (r_env[i] != '0);
    end
  end

  assign w_active_nxt = (|gate_in) | w_env_any;

  assign w_t1      = r_i1 + signed'(IW'(r_sum));
  assign w_t1_wrap = w_t1 - FS_I;

  assign w_sum_x = signed'(XW'(r_sum));
  assign w_fb_x  = r_sig ? FS_X : '0;
  assign w_i1n_x = XW'(r_i1) + w_sum_x - w_fb_x;
  assign w_i1n   = sat(w_i1n_x);
  assign w_i2n_x = XW'(r_i2) + XW'(w_i1n) - w_fb_x;
  assign w_i2n   = sat(w_i2n_x);

  // Tick divider and per-voice envelopes: one LSB toward the target per tick.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tick_cnt <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_env[i] <= '0;
      end
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
      if (w_tick) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (!gate_in[i]) begin
            if (r_env[i] != '0) begin
              r_env[i] <= r_env[i] - DATA_WIDTH'(1);
            end
          end else if (r_env[i] < dc_in[i*DATA_WIDTH +: DATA_WIDTH]) begin
            r_env[i] <= r_env[i] + DATA_WIDTH'(1);
          end else if (r_env[i] > dc_in[i*DATA_WIDTH +: DATA_WIDTH]) begin
            r_env[i] <= r_env[i] - DATA_WIDTH'(1);
          end
        end
      end
    end
  end

  // Mix register, mode tracking, activity flag and the sigma-delta core.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sum    <= '0;
      r_mode   <= 1'b0;
      r_active <= 1'b0;
      r_sig    <= 1'b0;
      r_i1     <= '0;
      r_i2     <= '0;
    end else begin
      r_sum    <= w_env_sum;
      r_mode   <= mode_in;
      r_active <= w_active_nxt;
      // A mode change or silence restarts the loop from a clean state.
      if ((mode_in != r_mode) || !w_active_nxt) begin
        r_sig <= 1'b0;
        r_i1  <= '0;
        r_i2  <= '0;
      end else if (!r_mode) begin
        r_i2 <= '0;
        if (w_t1 >= FS_I) begin
          r_sig <= 1'b1;
          r_i1  <= w_t1_wrap;
        end else begin
          r_sig <= 1'b0;
          r_i1  <= w_t1;
        end
      end else begin
        r_sig <= (w_i2n >= HALF_I);
        r_i1  <= w_i1n;
        r_i2  <= w_i2n;
      end
    end
  end

  assign sig_out    = r_sig;
  assign active_out = r_active;

endmodule

// File: tb/tb_pdm_poly_modulator.sv
// Self-checking bench for pdm_poly_modulator: hand-written envelope/mode sequences,
// a table of steady-state density vectors, and randomized runs against a behavioural model.
module tb_pdm_poly_modulator;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int RD = 4;
  localparam int FS = N * (2 ** DW);
  localparam int IMAX = 16383;
  localparam int IMIN = -16384;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] dc;
  logic [N-1:0]  gate;
  logic          mode;
  logic          sig_out;
  logic          active_out;

  pdm_poly_modulator #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .RAMP_DIV(RD)) dut (
    .clk_in(clk), .rst_in(rst), .dc_in(dc), .gate_in(gate), .mode_in(mode),
    .sig_out(sig_out), .active_out(active_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int mism    = 0;
  int bviol   = 0;

  // Behavioural reference state.
  int m_env [N];
  int m_cnt, m_sum, m_i1, m_i2, m_mode, m_sig, m_active;

  typedef struct {
    logic [7:0] gates;
    int         dcv;
    bit         md;
    int         win;
    int         lo;
    int         hi;
    int         act;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic end_phase(input string name);
    check({name, "_track"}, mism, 0);
    check({name, "_bounds"}, bviol, 0);
    mism  = 0;
    bviol = 0;
  endtask

  task automatic set_dc(input int idx, input int v);
    dc[idx*DW +: DW] = 8'(v);
  endtask

  function automatic int env_of(input int idx);
    return int'(dut.r_env[idx]);
  endfunction

  // One clock edge of the reference behaviour, applied to the inputs the DUT sees.
  task automatic model_step();
    int s, tgt, t, fb, i1n, i2n;
    bit any, act_n, tick;
    if (rst) begin
      for (int i = 0; i < N; i++) m_env[i] = 0;
      m_cnt = 0; m_sum = 0; m_i1 = 0; m_i2 = 0;
      m_mode = 0; m_sig = 0; m_active = 0;
      return;
    end
    s = 0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      s += m_env[i];
      if (m_env[i] != 0) any = 1'b1;
    end
    act_n = (gate != '0) || any;
    tick  = (m_cnt == RD - 1);
    if (tick) begin
      for (int i = 0; i < N; i++) begin
        tgt = int'(dc[i*DW +: DW]);
        if (!gate[i]) begin
          if (m_env[i] > 0) m_env[i]--;
        end else if (m_env[i] < tgt) begin
          m_env[i]++;
        end else if (m_env[i] > tgt) begin
          m_env[i]--;
        end
      end
    end
    if (int'(mode) != m_mode || !act_n) begin
      m_sig = 0; m_i1 = 0; m_i2 = 0;
    end else if (m_mode == 0) begin
      t = m_i1 + m_sum;
      if (t >= FS) begin m_sig = 1; m_i1 = t - FS; end
      else begin m_sig = 0; m_i1 = t; end
    end else begin
      fb  = (m_sig != 0) ? FS : 0;
      i1n = m_i1 + m_sum - fb;
      i2n = m_i2 + i1n - fb;
      m_sig = (i2n >= FS / 2) ? 1 : 0;
      m_i1 = i1n;
      m_i2 = i2n;
    end
    m_sum = s;
    m_mode = int'(mode);
    m_active = act_n ? 1 : 0;
    m_cnt = tick ? 0 : m_cnt + 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (sig_out !== 1'(m_sig) || active_out !== 1'(m_active)) mism++;
    if (m_i1 > IMAX || m_i1 < IMIN || m_i2 > IMAX || m_i2 < IMIN) bviol++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, ones, nz, prev, d, big, rose, k;

    tbl[0] = '{gates: 8'h00, dcv: 200, md: 1'b0, win: 2048, lo: 0,    hi: 0,    act: 0};
    tbl[1] = '{gates: 8'h01, dcv: 1,   md: 1'b0, win: 2048, lo: 1,    hi: 1,    act: 1};
    tbl[2] = '{gates: 8'h03, dcv: 64,  md: 1'b0, win: 2048, lo: 128,  hi: 128,  act: 1};
    tbl[3] = '{gates: 8'h0F, dcv: 128, md: 1'b1, win: 8192, lo: 1966, hi: 2130, act: 1};
    tbl[4] = '{gates: 8'h0F, dcv: 255, md: 1'b0, win: 2048, lo: 1020, hi: 1020, act: 1};
    tbl[5] = '{gates: 8'hFF, dcv: 255, md: 1'b0, win: 2048, lo: 2040, hi: 2040, act: 1};

    // Reset with random inputs applied.
    rst  = 1'b1;
    gate = 8'($urandom);
    dc   = {$urandom, $urandom};
    mode = 1'($urandom);
    repeat (3) step();
    nz = 0;
    for (int i = 0; i < N; i++) if (env_of(i) != 0) nz++;
    rst = 1'b0;
    check("reset_sig", int'(sig_out), 0);
    check("reset_active", int'(active_out), 0);
    check("reset_env_nonzero", nz, 0);
    repeat (20) step();
    end_phase("reset");

    // Attack to 100 and release back to 0 on voice 0.
    do_reset();
    dc = '0; mode = 1'b0; gate = 8'h01;
    set_dc(0, 100);
    cyc = 0;
    while (env_of(0) != 100 && cyc < 600) begin step(); cyc++; end
    check_range("attack_time", cyc, 396, 404);
    repeat (40) step();
    check("attack_hold", env_of(0), 100);
    gate = 8'h00;
    cyc = 0;
    while (env_of(0) != 0 && cyc < 600) begin step(); cyc++; end
    check_range("release_time", cyc, 396, 404);
    check("active_at_env_zero", int'(active_out), 1);
    step();
    check("active_fall", int'(active_out), 0);
    ones = 0;
    repeat (100) begin step(); ones += int'(sig_out); end
    check("silent_after_release", ones, 0);
    end_phase("ramp");

    // Retarget 150 -> 50 mid-attack at env 120.
    do_reset();
    dc = '0; gate = 8'h01;
    set_dc(0, 150);
    cyc = 0;
    while (env_of(0) != 120 && cyc < 700) begin step(); cyc++; end
    check("retarget_at120", env_of(0), 120);
    set_dc(0, 50);
    prev = 120; big = 0; rose = 0; cyc = 0;
    while (env_of(0) != 50 && cyc < 700) begin
      step(); cyc++;
      d = env_of(0) - prev;
      if (d > 0) rose++;
      if (d < -1) big++;
      prev = env_of(0);
    end
    check("retarget_reach50", env_of(0), 50);
    check("retarget_bigstep", big, 0);
    check("retarget_rise", rose, 0);
    repeat (40) step();
    check("retarget_hold", env_of(0), 50);
    end_phase("retarget");

    // Steady-state density table.
    for (int r = 0; r < 6; r++) begin
      gate = tbl[r].gates;
      mode = tbl[r].md;
      for (int i = 0; i < N; i++) set_dc(i, tbl[r].dcv);
      repeat (1100) step();
      ones = 0;
      for (int c = 0; c < tbl[r].win; c++) begin step(); ones += int'(sig_out); end
      check_range($sformatf("tbl%0d_ones", r), ones, tbl[r].lo, tbl[r].hi);
      check($sformatf("tbl%0d_active", r), int'(active_out), tbl[r].act);
      end_phase($sformatf("tbl%0d", r));
    end

    // Mode switch while modulating at sum 512.
    gate = 8'h0F; mode = 1'b0;
    for (int i = 0; i < N; i++) set_dc(i, 128);
    repeat (1100) step();
    mode = 1'b1;
    step();
    check("modesw1_sig", int'(sig_out), 0);
    check("modesw1_i1", int'(dut.r_i1), 0);
    check("modesw1_i2", int'(dut.r_i2), 0);
    ones = 0;
    repeat (512) begin step(); ones += int'(sig_out); end
    check_range("modesw1_ones", ones, 100, 156);
    mode = 1'b0;
    step();
    check("modesw0_sig", int'(sig_out), 0);
    check("modesw0_i1", int'(dut.r_i1), 0);
    ones = 0;
    repeat (2048) begin step(); ones += int'(sig_out); end
    check("modesw0_ones", ones, 512);
    end_phase("modesw");

    // Reset while active.
    rst = 1'b1;
    step();
    check("midreset_sig", int'(sig_out), 0);
    check("midreset_active", int'(active_out), 0);
    check("midreset_env0", env_of(0), 0);
    rst = 1'b0;
    repeat (50) step();
    end_phase("midreset");

    // Random first-order runs over the full amplitude range.
    for (int p = 0; p < 12; p++) begin
      gate = 8'($urandom);
      mode = 1'b0;
      for (int i = 0; i < N; i++) set_dc(i, $urandom_range(0, 255));
      repeat (150) step();
      k = $urandom_range(0, 7);
      gate[k] = 1'b0;
      set_dc(k, $urandom_range(0, 255));
      set_dc($urandom_range(0, 7), $urandom_range(0, 255));
      if (p == 5) begin rst = 1'b1; step(); rst = 1'b0; end
      repeat (150) step();
    end
    end_phase("randA");

    // Random mixed-order runs with moderate amplitudes.
    gate = 8'h00; mode = 1'b0;
    for (int i = 0; i < N; i++) set_dc(i, $urandom_range(0, 96));
    repeat (1100) step();
    for (int p = 0; p < 12; p++) begin
      gate = 8'($urandom);
      mode = 1'($urandom);
      for (int i = 0; i < N; i++) set_dc(i, $urandom_range(0, 96));
      repeat (125) step();
      if ($urandom_range(0, 1) == 1) mode = ~mode;
      k = $urandom_range(0, 7);
      gate[k] = ~gate[k];
      set_dc(k, $urandom_range(0, 96));
      repeat (125) step();
    end
    end_phase("randB");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pdm_poly_modulator.md
Name: pdm_poly_modulator

Overview:
- Polyphonic successor to the single-channel PDM output stage.
- Takes NUM_CHANNELS per-voice amplitudes with per-voice gates and applies a linear attack/release envelope to each voice, so gate edges do not click.
- Sums the enveloped voices and drives one PDM pin through a selectable 1st- or 2nd-order sigma-delta modulator.
- Sits between the voice/oscillator bank and the audio output pin.

Parameters:
- NUM_CHANNELS, 8, number of voices (>=1).
- DATA_WIDTH, 8, bits per voice amplitude.
- RAMP_DIV, 256, clock cycles per envelope step (>=1).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset. Synchronous, active-high.
- dc_in  input  NUM_CHANNELS*DATA_WIDTH  per-voice target amplitude. Voice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- gate_in  input  NUM_CHANNELS  per-voice gate. 1 = note on.
- mode_in  input  1  modulator order. 0 = 1st order, 1 = 2nd order.
- sig_out  output  1  PDM bitstream.
- active_out  output  1  high while any envelope is nonzero or any gate is high.

Behaviour:
- Clock and reset:
  - Single clock clk_in. rst_in is synchronous and active-high.
  - Reset clears: tick counter, all env[i], sum register, both integrators, registered mode. Drives sig_out=0 and active_out=0.
  - Reset asserted mid-operation takes effect at the next edge with no partial state retained.
- Derived constants:
  - SW = DATA_WIDTH + clog2(NUM_CHANNELS) + 1.
  - FS = NUM_CHANNELS * 2^DATA_WIDTH.
  - Integrators are signed, SW+3 bits.
- Tick generator:
  - tick_cnt counts 0..RAMP_DIV-1 and wraps.
  - tick is high in the cycle tick_cnt == RAMP_DIV-1.
  - With RAMP_DIV=1, tick is high every cycle.
- Envelope, per voice, updated only on tick:
  - gate=1 and env<dc: env+1.
  - gate=1 and env>dc: env-1 (tracks a lowered target).
  - gate=1 and env==dc: hold.
  - gate=0 and env>0: env-1 (release).
  - gate=0 and env==0: hold.
  - dc changes mid-ramp retarget from the current env value; no jumps.
  - env never wraps.
- Mix: sum_q <= sum of env[i], registered, 1 cycle after env.
- Registered mode:
  - mode_q <= mode_in.
  - When mode_in != mode_q, both integrators clear to 0 and sig_out <= 0 that cycle.
- Silence:
  - If active_out would be 0, sig_out <= 0 and both integrators clear.
  - active_out is registered: (|gate_in) | (any env != 0).
- First-order modulator (mode_q=0), per cycle:
  - t = i1 + sum_q.
  - If t >= FS: sig_out <= 1 and i1 <= t - FS.
  - Otherwise: sig_out <= 0 and i1 <= t.
  - Over FS cycles of constant sum_q, the count of ones is exactly sum_q.
- Second-order modulator (mode_q=1):
  - fb = sig_out ? FS : 0.
  - i1n = i1 + sum_q - fb.
  - i2n = i2 + i1n - fb.
  - sig_out <= (i2n >= FS/2).
  - i1 <= i1n, i2 <= i2n.
  - Must stay bounded (no integrator overflow) for 0 <= sum_q <= NUM_CHANNELS*(2^DATA_WIDTH-1).
- Latency:
  - gate/dc change to first env change: up to RAMP_DIV cycles.
  - env to sum_q: 1 cycle.
  - sum_q to sig_out: 1 cycle.
- Boundaries:
  - sum_q = 0 gives constant 0.
  - Maximum sum gives density (FS-NUM_CHANNELS)/FS, never a stuck 1.
  - Simultaneous gate-off and dc change: the release rule wins.

Test Plan:
- Reset check: assert rst_in 3 cycles with random inputs -> sig_out=0, active_out=0, env=0 on the cycle after rst_in deasserts.
- Attack/release ramp: N=8, DW=8, RAMP_DIV=4, voice 0 dc=100, gate=1 -> env0 reaches 100 after 400 cycles (±4), then holds. gate=0 -> env0 reaches 0 after 400 cycles; active_out falls 1 cycle later; sig_out stays 0 afterwards.
- First-order exactness: RAMP_DIV=1, voices 0-3 gated at dc=255, settled -> sum_q=1020; exactly 1020 ones in every aligned 2048-cycle window.
- Second-order density: mode_in=1, sum_q=512 -> ones density 0.25 ±1% over 8192 cycles; integrators never saturate or wrap (bench asserts bounds).
- Mode switch mid-stream: toggle mode_in while sig_out is active -> integrators read 0 and sig_out=0 on the following cycle, then modulation resumes in the new mode.
- Retarget while gated: dc0 150→50 mid-attack at env0=120 -> env0 decrements to 50 and holds, with no step larger than 1 per tick.
